// File: rtl/sme_pkg.sv
// Shared definitions for the SME host transmitter.
// Holds the character constants the SME gives special meaning to, the
// default buffer depths and the host FSM state type. The host forwards
// characters verbatim, so the character constants are here for software
// and test code that builds patterns.
package sme_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  localparam int STR_MAX_DEFAULT = 32;
  localparam int PAT_MAX_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT,
    ST_DONE
  } host_state_t;

endpackage

// File: rtl/sme_char_buf.sv
// Append-only character buffer with a saturating length.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (clears length)
//   clr               set length to 0 (wins over wr)
//   wr, wr_data       append wr_data at index len; dropped when full
//   rd_idx, rd_data   combinational read of one stored character
//   len               number of valid characters (0..DEPTH)
module sme_char_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = PAT_MAX_DEFAULT,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] len
);

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] len_q, len_d;
  logic          wr_en;

  // Next length: clear has priority, a write only lands while there is room.
  always_comb begin
    len_d = len_q;
    wr_en = 1'b0;
    if (clr) begin
      len_d = '0;
    end else if (wr && (len_q != LW'(DEPTH))) begin
      len_d = len_q + LW'(1);
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  // Contents are not reset; only the length defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[len_q[IW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign len     = len_q;

endmodule

// File: rtl/sme_host.sv
// Host-side transmitter for the string-matching engine.
// Buffers a string and a pattern, streams them over the SME character
// interface on start, waits for the engine result (or a timeout) and
// latches it into a result register.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   str_clr/str_wr, pat_clr/pat_wr  buffer clear / append (ignored while busy)
//   wr_data                         character to append
//   start, send_str                 launch; send_str=1 sends string then pattern
//   busy                            transaction in progress (through done)
//   chardata, isstring, ispattern   SME character interface (registered)
//   valid, match, match_index       SME result, only observed while waiting
//   done                            one-cycle pulse, result register updated
//   res_match/res_index/res_timeout/res_err  result register
module sme_host
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEFAULT,
  parameter int PAT_MAX = PAT_MAX_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       str_clr,
  input  logic       str_wr,
  input  logic       pat_clr,
  input  logic       pat_wr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       send_str,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       res_err
);

  localparam int SLW  = $clog2(STR_MAX + 1);
  localparam int PLW  = $clog2(PAT_MAX + 1);
  localparam int SIW  = $clog2(STR_MAX);
  localparam int PIW  = $clog2(PAT_MAX);
  localparam int IDXW = (SLW > PLW) ? SLW : PLW;
  localparam int TW   = $clog2(TIMEOUT + 1);

  logic [SLW-1:0] str_len;
  logic [PLW-1:0] pat_len;
  logic [7:0]     str_rd, pat_rd;
  logic [SIW-1:0] str_rd_idx;
  logic [PIW-1:0] pat_rd_idx;

  host_state_t     state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] str_n_q, str_n_d;
  logic [IDXW-1:0] pat_n_q, pat_n_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic [7:0]      chardata_q, chardata_d;
  logic            isstring_q, isstring_d;
  logic            ispattern_q, ispattern_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            res_match_q, res_match_d;
  logic [4:0]      res_index_q, res_index_d;
  logic            res_timeout_q, res_timeout_d;
  logic            res_err_q, res_err_d;

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (str_clr & ~busy_q),
    .wr      (str_wr & ~busy_q),
    .wr_data (wr_data),
    .rd_idx  (str_rd_idx),
    .rd_data (str_rd),
    .len     (str_len)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (pat_clr & ~busy_q),
    .wr      (pat_wr & ~busy_q),
    .wr_data (wr_data),
    .rd_idx  (pat_rd_idx),
    .rd_data (pat_rd),
    .len     (pat_len)
  );

  // The character for the next cycle is fetched one step ahead: outside its
  // own send state each buffer is read at index 0 so the first character is
  // ready on the edge that enters that state.
  assign str_rd_idx = (state_q == ST_SEND_STR) ? idx_q[SIW-1:0] : '0;
  assign pat_rd_idx = (state_q == ST_SEND_PAT) ? idx_q[PIW-1:0] : '0;

  // Next-state and next-output logic. idx_q counts characters already
  // presented in the current send state. Lengths are snapshotted at start so
  // a write landing in the start cycle cannot stretch the transfer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    str_n_d       = str_n_q;
    pat_n_d       = pat_n_q;
    wait_d        = wait_q;
    chardata_d    = 8'h00;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    res_err_d     = res_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          str_n_d = IDXW'(str_len);
          pat_n_d = IDXW'(pat_len);
          if ((pat_len == '0) || (send_str && (str_len == '0))) begin
            state_d       = ST_DONE;
            done_d        = 1'b1;
            res_err_d     = 1'b1;
            res_timeout_d = 1'b0;
            res_match_d   = 1'b0;
            res_index_d   = '0;
          end else if (send_str) begin
            state_d    = ST_SEND_STR;
            isstring_d = 1'b1;
            chardata_d = str_rd;
            idx_d      = IDXW'(1);
          end else begin
            state_d     = ST_SEND_PAT;
            ispattern_d = 1'b1;
            chardata_d  = pat_rd;
            idx_d       = IDXW'(1);
          end
        end
      end

      ST_SEND_STR: begin
        if (idx_q == str_n_q) begin
          state_d     = ST_SEND_PAT;
          ispattern_d = 1'b1;
          chardata_d  = pat_rd;
          idx_d       = IDXW'(1);
        end else begin
          isstring_d = 1'b1;
          chardata_d = str_rd;
          idx_d      = idx_q + IDXW'(1);
        end
      end

      ST_SEND_PAT: begin
        if (idx_q == pat_n_q) begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end else begin
          ispattern_d = 1'b1;
          chardata_d  = pat_rd;
          idx_d       = idx_q + IDXW'(1);
        end
      end

      // A result arriving on the final wait cycle still beats the timeout.
      ST_WAIT: begin
        if (valid) begin
          state_d       = ST_DONE;
          done_d        = 1'b1;
          res_match_d   = match;
          res_index_d   = match_index;
          res_timeout_d = 1'b0;
          res_err_d     = 1'b0;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          state_d       = ST_DONE;
          done_d        = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
          res_err_d     = 1'b0;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and outputs register here; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      str_n_q       <= '0;
      pat_n_q       <= '0;
      wait_q        <= '0;
      chardata_q    <= 8'h00;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      str_n_q       <= str_n_d;
      pat_n_q       <= pat_n_d;
      wait_q        <= wait_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
      res_err_q     <= res_err_d;
    end
  end

  assign busy        = busy_q;
  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;
  assign done        = done_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_sme_host.sv
// Self-checking bench for sme_host: directed table of transactions, a reset
// abort sequence and randomized transactions against a queue-based model of
// the buffers and the transfer/result rules.
module tb_sme_host;
  import sme_pkg::*;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 64;
  localparam int NVEC    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       str_clr, str_wr, pat_clr, pat_wr;
  logic [7:0] wr_data;
  logic       start, send_str;
  logic       busy;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       valid, match;
  logic [4:0] match_index;
  logic       done;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout, res_err;

  always #5 clk = ~clk;

  sme_host #(
    .STR_MAX (STR_MAX),
    .PAT_MAX (PAT_MAX),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .str_clr     (str_clr),
    .str_wr      (str_wr),
    .pat_clr     (pat_clr),
    .pat_wr      (pat_wr),
    .wr_data     (wr_data),
    .start       (start),
    .send_str    (send_str),
    .busy        (busy),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .done        (done),
    .res_match   (res_match),
    .res_index   (res_index),
    .res_timeout (res_timeout),
    .res_err     (res_err)
  );

  typedef struct {
    bit         ss;
    int         vdelay;
    bit         m;
    logic [4:0] mi;
    bit         e_err;
    bit         e_to;
    bit         e_match;
    logic [4:0] e_idx;
    int         e_ns;
    int         e_np;
  } vec_t;

  vec_t  vecs [NVEC];
  string vstr [NVEC];
  string vpat [NVEC];

  int errors = 0;
  int checks = 0;

  byte unsigned mstr[$];
  byte unsigned mpat[$];

  int         cap_ns, cap_np;
  bit         cap_err, cap_to, cap_match;
  logic [4:0] cap_idx;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle-time buffer cycle, mirrored into the model queues.
  task automatic apply_stimulus(input bit sc, input bit sw, input bit pc, input bit pw,
                                input byte unsigned d);
    str_clr = sc; str_wr = sw; pat_clr = pc; pat_wr = pw; wr_data = d;
    step();
    str_clr = 1'b0; str_wr = 1'b0; pat_clr = 1'b0; pat_wr = 1'b0;
    if (sc) mstr.delete();
    else if (sw && mstr.size() < STR_MAX) mstr.push_back(d);
    if (pc) mpat.delete();
    else if (pw && mpat.size() < PAT_MAX) mpat.push_back(d);
  endtask

  // Clear with a simultaneous write (clear must win), then append both texts.
  task automatic load(input string s, input string p);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < s.len(); i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, s[i]);
    for (int i = 0; i < p.len(); i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, p[i]);
  endtask

  function automatic byte unsigned rand_char();
    case ($urandom_range(0, 4))
      0:       return CH_CARET;
      1:       return CH_DOLLAR;
      2:       return CH_DOT;
      3:       return CH_SPACE;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic set_noise(input bit with_valid);
    start   = 1'($urandom);
    str_wr  = 1'($urandom);
    pat_wr  = 1'($urandom);
    str_clr = 1'($urandom);
    pat_clr = 1'($urandom);
    wr_data = 8'($urandom);
    if (with_valid) begin
      valid       = 1'($urandom);
      match       = 1'($urandom);
      match_index = 5'($urandom);
    end
  endtask

  task automatic clear_noise();
    start = 1'b0; str_wr = 1'b0; pat_wr = 1'b0; str_clr = 1'b0; pat_clr = 1'b0;
    valid = 1'b0;
  endtask

  // One full transaction. vdelay is the WAIT cycle (0-based) in which the
  // engine raises valid; negative or >= TIMEOUT means it never answers.
  task automatic run_txn(input bit ss, input int vdelay, input bit m, input logic [4:0] mi,
                         input bit noise);
    byte unsigned exp_q[$];
    bit           exp_kind[$];
    bit           exp_err, exp_to, got_done;
    int           exp_lat, n;

    exp_err = (mpat.size() == 0) || (ss && mstr.size() == 0);
    if (ss) foreach (mstr[i]) begin exp_q.push_back(mstr[i]); exp_kind.push_back(1'b1); end
    foreach (mpat[i]) begin exp_q.push_back(mpat[i]); exp_kind.push_back(1'b0); end
    exp_to  = (vdelay < 0) || (vdelay >= TIMEOUT);
    exp_lat = exp_to ? TIMEOUT : vdelay + 1;
    cap_ns = 0; cap_np = 0;

    start = 1'b1; send_str = ss;
    step();
    start = 1'b0; send_str = 1'b0;

    if (exp_err) begin
      check_output("err_done",     done,        1);
      check_output("err_flag",     res_err,     1);
      check_output("err_timeout",  res_timeout, 0);
      check_output("err_match",    res_match,   0);
      check_output("err_strobes",  {isstring, ispattern}, 0);
      check_output("err_busy",     busy,        1);
      cap_err = res_err; cap_to = res_timeout; cap_match = res_match; cap_idx = res_index;
      step();
      check_output("err_done_end", {done, busy}, 0);
      return;
    end

    for (int i = 0; i < exp_q.size(); i++) begin
      check_output("isstring",  isstring,  exp_kind[i]);
      check_output("ispattern", ispattern, !exp_kind[i]);
      check_output("chardata",  chardata,  exp_q[i]);
      check_output("send_busy", {busy, done}, 2'b10);
      if (isstring === 1'b1) cap_ns++;
      if (ispattern === 1'b1) cap_np++;
      if (noise) set_noise(1'b1);
      step();
      clear_noise();
    end

    check_output("wait_strobes",  {isstring, ispattern}, 0);
    check_output("wait_chardata", chardata, 0);
    check_output("wait_busy",     {busy, done}, 2'b10);

    n = 0;
    got_done = 1'b0;
    while (!got_done && n < TIMEOUT + 8) begin
      valid       = (n == vdelay);
      match       = valid ? m  : 1'($urandom);
      match_index = valid ? mi : 5'($urandom);
      if (noise) set_noise(1'b0);
      step();
      clear_noise();
      n++;
      got_done = (done === 1'b1);
    end

    check_output("done_latency", n, exp_lat);
    check_output("res_timeout",  res_timeout, exp_to);
    check_output("res_err",      res_err,     0);
    check_output("res_match",    res_match,   exp_to ? 1'b0 : m);
    check_output("res_index",    res_index,   exp_to ? 5'd0 : mi);
    check_output("done_busy",    busy,        1);
    cap_err = res_err; cap_to = res_timeout; cap_match = res_match; cap_idx = res_index;
    step();
    check_output("done_pulse_end", {done, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw_done;

    vecs[0] = '{1'b1, 2,  1'b1, 5'd2,  1'b0, 1'b0, 1'b1, 5'd2,  5,  2};
    vstr[0] = "HELLO";  vpat[0] = "LL";
    vecs[1] = '{1'b0, 0,  1'b0, 5'd7,  1'b0, 1'b0, 1'b0, 5'd7,  0,  3};
    vstr[1] = "IGNORED"; vpat[1] = "^A$";
    vecs[2] = '{1'b1, -1, 1'b1, 5'd9,  1'b0, 1'b1, 1'b0, 5'd0,  2,  2};
    vstr[2] = "AB";     vpat[2] = "XY";
    vecs[3] = '{1'b1, 5,  1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 5'd31, 32, 8};
    vstr[3] = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345678"; vpat[3] = "abcdefghi";
    vecs[4] = '{1'b1, 0,  1'b1, 5'd1,  1'b1, 1'b0, 1'b0, 5'd0,  0,  0};
    vstr[4] = "ABC";    vpat[4] = "";
    vecs[5] = '{1'b1, 0,  1'b1, 5'd1,  1'b1, 1'b0, 1'b0, 5'd0,  0,  0};
    vstr[5] = "";       vpat[5] = "Q";
    vecs[6] = '{1'b0, TIMEOUT - 1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 0, 1};
    vstr[6] = "";       vpat[6] = "Z";
    vecs[7] = '{1'b1, 10, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 5'd19, 6,  2};
    vstr[7] = "a.b^c$"; vpat[7] = ".$";

    reset = 1'b1;
    str_clr = 1'b0; str_wr = 1'b0; pat_clr = 1'b0; pat_wr = 1'b0; wr_data = 8'h00;
    start = 1'b0; send_str = 1'b0; valid = 1'b0; match = 1'b0; match_index = 5'd0;
    step();
    step();
    check_output("reset_outputs",
                 {busy, chardata, isstring, ispattern, done, res_match, res_index, res_timeout, res_err},
                 0);
    reset = 1'b0;
    step();
    check_output("post_reset_idle", {busy, done, isstring, ispattern}, 0);

    for (int v = 0; v < NVEC; v++) begin
      load(vstr[v], vpat[v]);
      run_txn(vecs[v].ss, vecs[v].vdelay, vecs[v].m, vecs[v].mi, 1'b0);
      check_output($sformatf("vec%0d_err", v),   cap_err,   vecs[v].e_err);
      check_output($sformatf("vec%0d_to", v),    cap_to,    vecs[v].e_to);
      check_output($sformatf("vec%0d_match", v), cap_match, vecs[v].e_match);
      check_output($sformatf("vec%0d_idx", v),   cap_idx,   vecs[v].e_idx);
      check_output($sformatf("vec%0d_nstr", v),  cap_ns,    vecs[v].e_ns);
      check_output($sformatf("vec%0d_npat", v),  cap_np,    vecs[v].e_np);
    end

    // Reset while the fourth string character is on the interface.
    load("HELLO", "LL");
    start = 1'b1; send_str = 1'b1;
    step();
    start = 1'b0; send_str = 1'b0;
    step(); step(); step();
    check_output("abort_pre_char", {isstring, chardata}, {1'b1, 8'h4C});
    #2 reset = 1'b1;
    #1;
    check_output("abort_strobes", {isstring, ispattern, busy, done}, 0);
    check_output("abort_chardata", chardata, 0);
    mstr.delete();
    mpat.delete();
    step();
    step();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    check_output("abort_no_done", saw_done, 0);
    run_txn(1'b1, 0, 1'b0, 5'd0, 1'b0);
    check_output("abort_lengths_zero", cap_err, 1);
    load("WORLD", "OR");
    run_txn(1'b1, 1, 1'b1, 5'd1, 1'b0);
    check_output("reload_match", {cap_match, cap_idx, cap_ns[7:0], cap_np[7:0]},
                 {1'b1, 5'd1, 8'd5, 8'd2});

    // Randomized transactions with busy-time noise on every input.
    for (int t = 0; t < 40; t++) begin
      int nops, vd;
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < 40; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, rand_char());
      end
      nops = $urandom_range(0, 6);
      for (int i = 0; i < nops; i++) begin
        apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0, rand_char());
      end
      case ($urandom_range(0, 7))
        0:       vd = -1;
        1:       vd = TIMEOUT - 1;
        default: vd = $urandom_range(0, 12);
      endcase
      run_txn(1'($urandom), vd, 1'($urandom), 5'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sme_host.md
# sme_host

Host-side transmitter for the string-matching engine (SME). It buffers one string (up to 32 chars) and one pattern (up to 8 chars) and, on `start`, streams them over the SME character interface (`chardata`/`isstring`/`ispattern`). It then waits for the engine's `valid` and latches `match`/`match_index` into a result register. Sits between the system command path and the SME instance; it is the initiating end of the SME protocol.

## Interface
- `STR_MAX`, 32: string buffer depth in chars.
- `PAT_MAX`, 8: pattern buffer depth in chars.
- `TIMEOUT`, 64: cycles allowed in WAIT before abort.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `str_clr` in 1: set string length to 0.
- `str_wr` in 1: append `wr_data` to the string buffer.
- `pat_clr` in 1: set pattern length to 0.
- `pat_wr` in 1: append `wr_data` to the pattern buffer.
- `wr_data` in 8: character for `str_wr`/`pat_wr`.
- `start` in 1: launch a transaction.
- `send_str` in 1: sampled with `start`. 1 sends string then pattern; 0 sends pattern only, and the SME reuses its stored string.
- `busy` out 1: transaction in progress.
- `chardata` out 8: character to the SME.
- `isstring` out 1: `chardata` is a string char.
- `ispattern` out 1: `chardata` is a pattern char.
- `valid` in 1: SME result strobe.
- `match` in 1: SME match flag.
- `match_index` in 5: SME match position.
- `done` out 1: one-cycle pulse when the result register has been updated.
- `res_match` out 1, `res_index` out 5, `res_timeout` out 1, `res_err` out 1: result register, held until the next `done`.

## Operation
- Buffers:
  - Each write appends at index = current length, then length increments.
  - Writes when length == max are dropped and length saturates.
  - `clr` and `wr` in the same cycle: clear wins.
  - Writes and clears while `busy`=1 are ignored.
  - Characters are forwarded verbatim. Meta-chars `^`(0x5E), `$`(0x24) and `.`(0x2E) are not interpreted.
- FSM states: IDLE, SEND_STR, SEND_PAT, WAIT, DONE.
- IDLE, on `start`:
  - If pat_len==0, or `send_str`=1 with str_len==0 → DONE with `res_err`=1.
  - Else if `send_str`=1 → SEND_STR.
  - Else → SEND_PAT.
  - `start` while not IDLE is ignored.
- SEND_STR: one char per cycle, index 0..str_len-1, `isstring`=1. After the last char → SEND_PAT with no gap cycle.
- SEND_PAT: one char per cycle, `ispattern`=1. After the last char → WAIT.
- WAIT:
  - `valid`=1 → latch `match` and `match_index`; `res_timeout`=0, `res_err`=0; → DONE.
  - Wait counter reaches TIMEOUT → `res_timeout`=1, `res_match`=0, `res_index`=0; → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `valid` outside WAIT is ignored.
- Never `isstring`=1 and `ispattern`=1 together. When neither is asserted, `chardata`=0x00.
- Reset values: all outputs 0, both lengths 0, FSM IDLE, buffer contents don't-care.
- Reset mid-transaction aborts immediately: strobes drop asynchronously and no `done` is issued.

## Timing
- All outputs are registered.
- `start` sampled at edge T. First char is on the SME interface in cycle T+1.
- Transmission spans cycles T+1 .. T+L+P, where L = str_len (or 0 when `send_str`=0) and P = pat_len.
- WAIT begins at cycle T+L+P+1. The wait counter starts at 0 and counts WAIT cycles.
- `valid` sampled at edge V → `done` and the updated result in cycle V+1.
- Timeout: `done` in cycle T+L+P+1+TIMEOUT.
- Error path: `done` in cycle T+1. No strobes are driven.
- `busy`=1 from T+1 through the `done` cycle inclusive. A new `start` is accepted the cycle after `done`.

## Structure
- Package `sme_pkg`:
  - Constants `CH_CARET`=0x5E, `CH_DOLLAR`=0x24, `CH_DOT`=0x2E, `CH_SPACE`=0x20.
  - `STR_MAX`/`PAT_MAX` defaults.
  - FSM state enum `host_state_t`.
- Sub-module `sme_char_buf` (parameter DEPTH):
  - Write-append port, clear, saturating length, combinational read by index.
  - Instantiated twice, for string and for pattern.
- Top level: FSM, send index counter, wait counter, result register.

## Test plan
- Load string "HELLO" and pattern "LL". Pulse `start` with `send_str`=1; the SME model returns `valid` with `match`=1, `match_index`=2 three cycles after the last pattern char.
  - Expect `isstring`=1 for 5 cycles carrying 48 45 4C 4C 4F.
  - Then `ispattern`=1 for 2 cycles carrying 4C 4C.
  - Then `done` with `res_match`=1, `res_index`=2.
- Load pattern "^A$" and start with `send_str`=0.
  - Expect only `ispattern` cycles carrying 5E 41 24, no `isstring`.
  - Model returns `match`=0 → `res_match`=0.
- Model never asserts `valid`.
  - Expect `done` exactly TIMEOUT cycles after WAIT entry, with `res_timeout`=1.
- Write 35 chars to the string buffer, then send.
  - Expect exactly 32 `isstring` cycles.
  - Write 9 pattern chars → expect 8 `ispattern` cycles.
- Start with pat_len=0 → `done` at T+1, `res_err`=1, no strobes. Start while `busy` → ignored.
- Assert `reset` during SEND_STR char 3.
  - Expect `isstring`/`ispattern`/`busy` low immediately, no `done`, lengths 0.
  - A subsequent reload and send works.
